// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared mode constants, bar colour table and channel expansion for rgb_pixel_fmt
package rgb_pkg;

    typedef enum logic [1:0] {
        MODE_RGB  = 2'd0,
        MODE_GREY = 2'd1,
        MODE_BARS = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int MAX_IN_BITS  = 8;
    localparam int MAX_OUT_BITS = 10;
    localparam int IN_IDX_W     = $clog2(MAX_IN_BITS);
    localparam int OUT_IDX_W    = $clog2(MAX_OUT_BITS);

    // {R,G,B} on/off code for bar k is 7-k: white first, black last.
    localparam logic [2:0] BAR_CODE [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    // Repeats the low in_bits of ch MSB-first; result is left-aligned, callers keep the top bits.
    function automatic logic [MAX_OUT_BITS-1:0] expand_chan(input logic [MAX_IN_BITS-1:0] ch,
                                                           input int in_bits);
        logic [MAX_OUT_BITS-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_OUT_BITS; i++) begin
            res[OUT_IDX_W'(MAX_OUT_BITS - 1 - i)] = ch[IN_IDX_W'(in_bits - 1 - (i % in_bits))];
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb_bar_gen.sv
// rtl/rgb_bar_gen.sv - colour-bar pixel counter and colour lookup, aligned with pipeline stage 1
module rgb_bar_gen
    import rgb_pkg::*;
#(
    parameter int BAR_W = 80
) (
    input  logic       Clk,
    input  logic       Nreset,
    input  logic       Nblank,
    output logic [2:0] code
);

    localparam int            CW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    // cnt/idx give the position of the next incoming pixel; code is registered alongside it.
    always_ff @(posedge Clk or negedge Nreset) begin
        if (!Nreset) begin
            cnt  <= '0;
            idx  <= '0;
            code <= '0;
        end else if (!Nblank) begin
            cnt  <= '0;
            idx  <= '0;
            code <= '0;
        end else begin
            code <= BAR_CODE[idx];
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_pixel_fmt.sv
// rtl/rgb_pixel_fmt.sv - two-stage RGB formatter (expand/grey/bars, blanking); bars built only with RGB_PIXEL_FMT_TESTPAT_EN
module rgb_pixel_fmt
    import rgb_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 8,
    parameter int BAR_W    = 80
) (
    input  logic                   Clk,
    input  logic                   Nreset,
    input  logic [3*IN_BITS-1:0]   Din,
    input  logic                   Nblank,
    input  logic                   Hsync,
    input  logic                   Vsync,
    input  logic [1:0]             Mode,
    output logic [OUT_BITS-1:0]    R,
    output logic [OUT_BITS-1:0]    G,
    output logic [OUT_BITS-1:0]    B,
    output logic                   Nblank_o,
    output logic                   Hsync_o,
    output logic                   Vsync_o
);

    if (IN_BITS < 1 || IN_BITS > MAX_IN_BITS) begin : g_bad_in_bits
        $error("rgb_pixel_fmt: IN_BITS must be 1..8");
    end
    if (OUT_BITS < 1 || OUT_BITS > MAX_OUT_BITS) begin : g_bad_out_bits
        $error("rgb_pixel_fmt: OUT_BITS must be 1..10");
    end
    if (BAR_W < 1) begin : g_bad_bar_w
        $error("rgb_pixel_fmt: BAR_W must be at least 1");
    end

    logic [3*IN_BITS-1:0] din_q;
    logic                 nblank_q;
    logic                 hsync_q;
    logic                 vsync_q;
    mode_e                mode_q;

    always_ff @(posedge Clk or negedge Nreset) begin
        if (!Nreset) begin
            din_q    <= '0;
            nblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            mode_q   <= MODE_RGB;
        end else begin
            din_q    <= Din;
            nblank_q <= Nblank;
            hsync_q  <= Hsync;
            vsync_q  <= Vsync;
            mode_q   <= mode_e'(Mode);
        end
    end

`ifdef RGB_PIXEL_FMT_TESTPAT_EN
    logic [2:0] bar_code;

    rgb_bar_gen #(
        .BAR_W (BAR_W)
    ) u_bar_gen (
        .Clk    (Clk),
        .Nreset (Nreset),
        .Nblank (Nblank),
        .code   (bar_code)
    );
`endif

    function automatic logic [OUT_BITS-1:0] widen(input logic [IN_BITS-1:0] ch);
        return OUT_BITS'(expand_chan(MAX_IN_BITS'(ch), IN_BITS) >> (MAX_OUT_BITS - OUT_BITS));
    endfunction

    logic [IN_BITS-1:0]   r_in, g_in, b_in;
    logic [IN_BITS+1:0]   y_sum;
    logic [IN_BITS-1:0]   y;
    logic [IN_BITS-1:0]   r_sel, g_sel, b_sel;
    logic [OUT_BITS-1:0]  r_nxt, g_nxt, b_nxt;

    assign r_in  = din_q[3*IN_BITS-1 -: IN_BITS];
    assign g_in  = din_q[2*IN_BITS-1 -: IN_BITS];
    assign b_in  = din_q[IN_BITS-1:0];
    assign y_sum = {2'b00, r_in} + {1'b0, g_in, 1'b0} + {2'b00, b_in};
    assign y     = IN_BITS'(y_sum >> 2);

    always_comb begin
        r_sel = r_in;
        g_sel = g_in;
        b_sel = b_in;
        if (mode_q == MODE_GREY) begin
            r_sel = y;
            g_sel = y;
            b_sel = y;
        end
        r_nxt = widen(r_sel);
        g_nxt = widen(g_sel);
        b_nxt = widen(b_sel);
`ifdef RGB_PIXEL_FMT_TESTPAT_EN
        if (mode_q == MODE_BARS) begin
            r_nxt = {OUT_BITS{bar_code[2]}};
            g_nxt = {OUT_BITS{bar_code[1]}};
            b_nxt = {OUT_BITS{bar_code[0]}};
        end
`endif
        if (!nblank_q) begin
            r_nxt = '0;
            g_nxt = '0;
            b_nxt = '0;
        end
    end

    always_ff @(posedge Clk or negedge Nreset) begin
        if (!Nreset) begin
            R        <= '0;
            G        <= '0;
            B        <= '0;
            Nblank_o <= 1'b0;
            Hsync_o  <= 1'b0;
            Vsync_o  <= 1'b0;
        end else begin
            R        <= r_nxt;
            G        <= g_nxt;
            B        <= b_nxt;
            Nblank_o <= nblank_q;
            Hsync_o  <= hsync_q;
            Vsync_o  <= vsync_q;
        end
    end

endmodule

// File: tb/tb_rgb_pixel_fmt.sv
// tb/tb_rgb_pixel_fmt.sv - table-driven and sequence checks for rgb_pixel_fmt
module tb_rgb_pixel_fmt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] din = '0;
    logic [14:0] din5 = '0;
    logic [23:0] din8 = '0;
    logic        nblank = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [1:0]  mode = 2'd0;

    logic [7:0]  r, g, b;
    logic        nb_o, hs_o, vs_o;
    logic [7:0]  r5, g5, b5;
    logic        nb5, hs5, vs5;
    logic [5:0]  r8, g8, b8;
    logic        nb8, hs8, vs8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_pixel_fmt #(.IN_BITS(4), .OUT_BITS(8), .BAR_W(2)) dut (
        .Clk(clk), .Nreset(rst_n), .Din(din), .Nblank(nblank), .Hsync(hsync), .Vsync(vsync),
        .Mode(mode), .R(r), .G(g), .B(b), .Nblank_o(nb_o), .Hsync_o(hs_o), .Vsync_o(vs_o)
    );

    rgb_pixel_fmt #(.IN_BITS(5), .OUT_BITS(8), .BAR_W(2)) dut5 (
        .Clk(clk), .Nreset(rst_n), .Din(din5), .Nblank(nblank), .Hsync(hsync), .Vsync(vsync),
        .Mode(mode), .R(r5), .G(g5), .B(b5), .Nblank_o(nb5), .Hsync_o(hs5), .Vsync_o(vs5)
    );

    rgb_pixel_fmt #(.IN_BITS(8), .OUT_BITS(6), .BAR_W(2)) dut8 (
        .Clk(clk), .Nreset(rst_n), .Din(din8), .Nblank(nblank), .Hsync(hsync), .Vsync(vsync),
        .Mode(mode), .R(r8), .G(g8), .B(b8), .Nblank_o(nb8), .Hsync_o(hs8), .Vsync_o(vs8)
    );

    typedef struct {
        logic [11:0] din;
        logic        nblank;
        logic        hsync;
        logic        vsync;
        logic [1:0]  mode;
        logic [7:0]  er;
        logic [7:0]  eg;
        logic [7:0]  eb;
        logic        enb;
        logic        ehs;
        logic        evs;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_rgb(input string name, input logic [7:0] er, input logic [7:0] eg,
                           input logic [7:0] eb);
        chk({name, ".R"}, 32'(r), 32'(er));
        chk({name, ".G"}, 32'(g), 32'(eg));
        chk({name, ".B"}, 32'(b), 32'(eb));
    endtask

    // Expected pixel p of a bar run with BAR_W=2 and Din=A5C.
    task automatic bar_exp(input int p, output logic [7:0] er, output logic [7:0] eg,
                           output logic [7:0] eb);
`ifdef RGB_PIXEL_FMT_TESTPAT_EN
        logic [2:0] code;
        code = 3'(7 - ((p / 2) % 8));
        er = code[2] ? 8'hFF : 8'h00;
        eg = code[1] ? 8'hFF : 8'h00;
        eb = code[0] ? 8'hFF : 8'h00;
`else
        er = 8'hAA;
        eg = 8'h55;
        eb = 8'hCC;
`endif
    endtask

    initial begin
        logic [7:0] er, eg, eb;

        vecs[0] = '{12'hA5C, 1'b1, 1'b0, 1'b0, 2'd0, 8'hAA, 8'h55, 8'hCC, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{12'hA5C, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{12'h8C4, 1'b1, 1'b0, 1'b1, 2'd1, 8'h99, 8'h99, 8'h99, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{12'hA5C, 1'b1, 1'b0, 1'b0, 2'd3, 8'hAA, 8'h55, 8'hCC, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{12'hFFF, 1'b1, 1'b0, 1'b0, 2'd1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{12'h000, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{12'h123, 1'b1, 1'b0, 1'b0, 2'd1, 8'h22, 8'h22, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{12'hA5C, 1'b0, 1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};

        // Reset state, with inputs active so nothing can leak through.
        din = 12'hA5C; nblank = 1'b1; hsync = 1'b1; vsync = 1'b1;
        step();
        step();
        chk_rgb("reset", 8'h00, 8'h00, 8'h00);
        chk("reset.Nblank_o", 32'(nb_o), 32'h0);
        chk("reset.Hsync_o", 32'(hs_o), 32'h0);
        chk("reset.Vsync_o", 32'(vs_o), 32'h0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            din = vecs[i].din; nblank = vecs[i].nblank; hsync = vecs[i].hsync;
            vsync = vecs[i].vsync; mode = vecs[i].mode;
            step();
            step();
            chk_rgb($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
            chk($sformatf("vec%0d.Nblank_o", i), 32'(nb_o), 32'(vecs[i].enb));
            chk($sformatf("vec%0d.Hsync_o", i), 32'(hs_o), 32'(vecs[i].ehs));
            chk($sformatf("vec%0d.Vsync_o", i), 32'(vs_o), 32'(vecs[i].evs));
        end

        // Other channel widths: replication up (5->8) and truncation down (8->6).
        din5 = {5'b10110, 5'b00001, 5'b11111};
        din8 = {8'hF3, 8'h81, 8'h0F};
        nblank = 1'b1; hsync = 1'b0; vsync = 1'b0; mode = 2'd0;
        step();
        step();
        chk("w5.R", 32'(r5), 32'hB5);
        chk("w5.G", 32'(g5), 32'h08);
        chk("w5.B", 32'(b5), 32'hFF);
        chk("w5.Nblank_o", 32'(nb5), 32'h1);
        chk("w8.R", 32'(r8), 32'h3C);
        chk("w8.G", 32'(g8), 32'h20);
        chk("w8.B", 32'(b8), 32'h03);
        chk("w8.Nblank_o", 32'(nb8), 32'h1);

        // Latency: a single distinct pixel must appear exactly two edges later.
        din = 12'hA5C; mode = 2'd0; nblank = 1'b1;
        step();
        din = 12'h123; mode = 2'd1;
        step();
        din = 12'hA5C; mode = 2'd0;
        chk_rgb("lat.before", 8'hAA, 8'h55, 8'hCC);
        step();
        chk_rgb("lat.at", 8'h22, 8'h22, 8'h22);
        step();
        chk_rgb("lat.after", 8'hAA, 8'h55, 8'hCC);

        // Bar run: one blank cycle resets the counter, then 18 active pixels plus wrap.
        din = 12'hA5C; nblank = 1'b0; mode = 2'd2;
        step();
        nblank = 1'b1;
        step();
        for (int p = 0; p < 19; p++) begin
            step();
            bar_exp(p, er, eg, eb);
            chk_rgb($sformatf("bar.p%0d", p), er, eg, eb);
        end

        // Single-cycle blank mid-line restarts at white.
        nblank = 1'b0;
        step();
        nblank = 1'b1;
        step();
        chk_rgb("glitch.blank", 8'h00, 8'h00, 8'h00);
        chk("glitch.Nblank_o", 32'(nb_o), 32'h0);
        step();
        bar_exp(0, er, eg, eb);
        chk_rgb("glitch.restart", er, eg, eb);
        for (int k = 0; k < 4; k++) step();
        bar_exp(4, er, eg, eb);
        chk_rgb("prereset.p4", er, eg, eb);

        // Asynchronous reset mid-bar, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk_rgb("midreset", 8'h00, 8'h00, 8'h00);
        chk("midreset.Nblank_o", 32'(nb_o), 32'h0);
        #1 rst_n = 1'b1;
        step();
        step();
        bar_exp(0, er, eg, eb);
        chk_rgb("postreset", er, eg, eb);
        chk("postreset.Nblank_o", 32'(nb_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
